// File: rtl/merge_loader_pkg.sv
// Shared definitions for the merge stage load feeder.
//   state_t   : controller states, 3-bit encoding
//   cnt_width : element counter width, max(1, $clog2(n+1))
package merge_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL_A = 3'd1,
    LOAD_A = 3'd2,
    FILL_B = 3'd3,
    LOAD_B = 3'd4,
    DONE   = 3'd5
  } state_t;

  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/merge_loader_packer.sv
// Pack register for the two load halves. Each write places one element
// into slot (half*N + idx); every other slot keeps its value.
//   clk, rst : clock, synchronous active-high reset (clears the register)
//   half     : 0 = half A, 1 = half B
//   idx      : element index within the half
//   we       : write enable
//   data     : element to store
//   pack     : packed bus, half A in the low N*WIDTH bits
module elem_packer
  import merge_loader_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int N     = 2,
  parameter int CW    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   half,
  input  logic [CW-1:0]          idx,
  input  logic                   we,
  input  logic [WIDTH-1:0]       data,
  output logic [2*N*WIDTH-1:0]   pack
);

  int slot;

  always_comb begin
    slot = (half ? N : 0) + int'(idx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pack <= '0;
    end else if (we) begin
      for (int k = 0; k < 2 * N; k++) begin
        if (k == slot) pack[k*WIDTH +: WIDTH] <= data;
      end
    end
  end

endmodule

// File: rtl/merge_loader.sv
// Writer-side feeder for the merge stage's two-half load register.
// Packs N serial elements into half A, strobes load[0], packs N more into
// half B, strobes load[1], then pulses done.
//
// Handshake: an element transfers in every cycle where in_valid and
// in_ready are both high at the rising edge. in_ready depends only on the
// registered state, never on in_valid; the source may hold or drop
// in_valid freely and the block does not require in_valid to stay high.
//
//   clk, rst  : clock, synchronous active-high reset
//   start     : begin one A+B fill (only sampled in IDLE)
//   in_valid  : element present on in_data
//   in_data   : element
//   in_ready  : element accepted this cycle when in_valid is high
//   load      : load[0] strobes half A, load[1] strobes half B
//   inba      : packed bus straight from the pack register
//   busy      : high outside IDLE
//   done      : one-cycle pulse after the half-B strobe
//   state_dbg : registered controller state
module merge_loader
  import merge_loader_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int N     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 in_ready,
  output logic [1:0]           load,
  output logic [2*N*WIDTH-1:0] inba,
  output logic                 busy,
  output logic                 done,
  output state_t               state_dbg
);

  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          last_elem;
  logic          half;

  assign accept    = in_valid && in_ready;
  assign last_elem = (cnt == LAST);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    load       = 2'b00;
    busy       = 1'b1;
    done       = 1'b0;
    half       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = FILL_A;
      end
      FILL_A: begin
        in_ready = 1'b1;
        if (accept && last_elem) state_next = LOAD_A;
      end
      LOAD_A: begin
        load       = 2'b01;
        state_next = FILL_B;
      end
      FILL_B: begin
        in_ready = 1'b1;
        half     = 1'b1;
        if (accept && last_elem) state_next = LOAD_B;
      end
      LOAD_B: begin
        load       = 2'b10;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Cleared on entry to each fill; wraps back to 0 on the last element so
  // it never reaches N.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == IDLE || state == LOAD_A) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= last_elem ? '0 : cnt + CW'(1);
    end
  end

  elem_packer #(.WIDTH(WIDTH), .N(N), .CW(CW)) u_packer (
    .clk  (clk),
    .rst  (rst),
    .half (half),
    .idx  (cnt),
    .we   (accept),
    .data (in_data),
    .pack (inba)
  );

endmodule

// File: tb/tb_merge_loader.sv
module tb_merge_loader;
  import merge_loader_pkg::*;

  localparam int W  = 3;
  localparam int N  = 2;
  localparam int L  = 64;
  localparam int BW = 2 * N * W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready;
  logic [1:0]    load;
  logic [BW-1:0] inba;
  logic          busy;
  logic          done;
  state_t        state_dbg;

  merge_loader #(.WIDTH(W), .N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .load(load), .inba(inba),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // n=1, WIDTH=8 edge-case instance
  logic        start2 = 1'b0;
  logic        in_valid2 = 1'b0;
  logic [7:0]  in_data2 = '0;
  logic        in_ready2;
  logic [1:0]  load2;
  logic [15:0] inba2;
  logic        busy2;
  logic        done2;
  state_t      state_dbg2;

  merge_loader #(.WIDTH(8), .N(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid2),
    .in_data(in_data2), .in_ready(in_ready2), .load(load2), .inba(inba2),
    .busy(busy2), .done(done2), .state_dbg(state_dbg2)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- stimulus pattern + reference model ----------------
  logic         v_pat[L];
  logic [W-1:0] d_pat[L];
  logic         s_pat[L];

  logic [BW-1:0] exp_pack = '0;   // model of the pack register contents
  logic [BW-1:0] exp_q[$];        // expected inba at each load strobe
  int obs_la, obs_lb, obs_done, obs_dones;
  logic [BW-1:0] obs_inba_lb;

  task automatic clear_pat();
    for (int i = 0; i < L; i++) begin
      v_pat[i] = 1'b1;
      d_pat[i] = '0;
      s_pat[i] = 1'b0;
    end
  endtask

  // Run one transaction from the pattern. start is raised in cycle 0.
  // rst_at >= 0 asserts rst during that cycle.
  task automatic run_txn(input int rst_at);
    int c, cnt, a_end, b_end, last, k;
    logic          e_ready, e_busy, e_done;
    logic [1:0]    e_load;
    logic [BW-1:0] snap;
    // Timeline from the rules: fill windows consume N valid cycles each,
    // with one load cycle between and after them.
    c = 1;
    snap = exp_pack;
    for (int h = 0; h < 2; h++) begin
      cnt = 0;
      while (cnt < N) begin
        if (v_pat[c]) begin
          snap[(h*N + cnt)*W +: W] = d_pat[c];
          cnt++;
        end
        c++;
      end
      if (h == 0) begin
        a_end = c - 1;
        exp_q.push_back(snap);
        c++;
      end
    end
    b_end = c - 1;
    exp_q.push_back(snap);
    last = b_end + 3;

    obs_la = -1; obs_lb = -1; obs_done = -1; obs_dones = 0; obs_inba_lb = '0;
    k = 0;
    for (int cy = 0; cy <= last; cy++) begin
      @(posedge clk); #1;
      rst      = (cy == rst_at);
      start    = (cy == 0) ? 1'b1 : ((cy == last || cy > rst_at && rst_at >= 0) ? 1'b0 : s_pat[cy]);
      in_valid = v_pat[cy];
      in_data  = d_pat[cy];
      @(negedge clk);
      if (rst_at >= 0 && cy == rst_at + 1) begin
        exp_pack = '0;
        exp_q.delete();
        check("rst_ready", in_ready, 1'b0);
        check("rst_load",  load, 2'b00);
        check("rst_busy",  busy, 1'b0);
        check("rst_done",  done, 1'b0);
        check("rst_inba",  inba, exp_pack);
        break;
      end
      e_busy  = (cy >= 1 && cy <= b_end + 2);
      e_ready = (cy >= 1 && cy <= a_end) || (cy >= a_end + 2 && cy <= b_end);
      e_load  = (cy == a_end + 1) ? 2'b01 : (cy == b_end + 1) ? 2'b10 : 2'b00;
      e_done  = (cy == b_end + 2);
      check("busy",     busy, e_busy);
      check("in_ready", in_ready, e_ready);
      check("load",     load, e_load);
      check("done",     done, e_done);
      check("inba",     inba, exp_pack);
      if (load != 2'b00) begin
        if (exp_q.size() == 0) check("strobe_unexpected", load, 2'b00);
        else check("strobe_inba", inba, exp_q.pop_front());
      end
      if (load[0]) obs_la = cy;
      if (load[1]) begin obs_lb = cy; obs_inba_lb = inba; end
      if (done) begin obs_done = cy; obs_dones++; end
      if (e_ready && v_pat[cy]) begin
        exp_pack[k*W +: W] = d_pat[cy];
        k++;
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    exp_q.delete();
  endtask

  task automatic basic_pat();
    clear_pat();
    d_pat[1] = 3'd3; d_pat[2] = 3'd5; d_pat[4] = 3'd1; d_pat[5] = 3'd7;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ready", in_ready, 1'b0);
    check("reset_load",  load, 2'b00);
    check("reset_busy",  busy, 1'b0);
    check("reset_done",  done, 1'b0);
    check("reset_inba",  inba, 12'h000);
    check("reset_state", state_dbg, IDLE);

    // basic fill
    basic_pat();
    run_txn(-1);
    check("basic_la",   obs_la, 3);
    check("basic_lb",   obs_lb, 6);
    check("basic_done", obs_done, 7);
    check("basic_inba", obs_inba_lb, 12'hE6B);

    // gaps: two idle cycles after the first element
    clear_pat();
    v_pat[2] = 1'b0; v_pat[3] = 1'b0;
    d_pat[1] = 3'd3; d_pat[4] = 3'd5; d_pat[6] = 3'd1; d_pat[7] = 3'd7;
    run_txn(-1);
    check("gap_la",   obs_la, 5);
    check("gap_lb",   obs_lb, 8);
    check("gap_done", obs_done, 9);
    check("gap_inba", obs_inba_lb, 12'hE6B);

    // reset in the cycle after LOAD_A
    basic_pat();
    run_txn(4);
    check("rstmid_no_lb",   obs_lb, -1);
    check("rstmid_no_done", obs_dones, 0);
    basic_pat();
    run_txn(-1);
    check("rstmid_fresh_inba", obs_inba_lb, 12'hE6B);
    check("rstmid_fresh_done", obs_done, 7);

    // start pulse during FILL_B is ignored
    basic_pat();
    s_pat[4] = 1'b1;
    run_txn(-1);
    check("ign_start_dones", obs_dones, 1);
    check("ign_start_lb",    obs_lb, 6);

    // randomized transactions
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < L; i++) begin
        v_pat[i] = (i >= 40) ? 1'b1 : ($urandom_range(0, 9) < 7);
        d_pat[i] = W'($urandom);
        s_pat[i] = ($urandom_range(0, 3) == 0);
      end
      run_txn(($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 6)) : -1);
    end

    // n=1, WIDTH=8 edge case
    for (int cy = 0; cy <= 6; cy++) begin
      @(posedge clk); #1;
      start2    = (cy == 0);
      in_valid2 = 1'b1;
      in_data2  = (cy == 1) ? 8'hA5 : (cy == 3) ? 8'h3C : 8'($urandom);
      @(negedge clk);
      check("n1_load", load2, (cy == 2) ? 2'b01 : (cy == 4) ? 2'b10 : 2'b00);
      check("n1_done", done2, (cy == 5));
      check("n1_busy", busy2, (cy >= 1 && cy <= 5));
      if (cy == 4 || cy == 6) check("n1_inba", inba2, 16'h3CA5);
      if (cy == 2) check("n1_inba_a", inba2[7:0], 8'hA5);
    end
    @(posedge clk); #1;
    in_valid2 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/merge_loader.md
# merge_loader

Writer-side feeder for the merge stage's two-half load register. It accepts a serial stream of WIDTH-bit elements over a valid/ready handshake and packs n elements into half A, then n elements into half B. After each half is complete it drives a one-cycle load strobe with the packed bus, so the downstream register captures that half. It sits between the element source (the sorter's serial output) and the merge input register.

## Interface
- WIDTH, 3, bits per element
- n, 2, elements per half (n ≥ 1)
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous and active-high
- start  in  1  begin one A+B fill; sampled only in IDLE
- in_valid  in  1  element present on in_data
- in_data  in  WIDTH  element
- in_ready  out  1  block accepts in_data this cycle
- load  out  2  load[0] strobes half A, load[1] strobes half B; never both set
- inba  out  2*n*WIDTH  packed bus; half A in [n*WIDTH-1:0], half B in [2*n*WIDTH-1:n*WIDTH]
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the half-B strobe

## Operation
- States: IDLE, FILL_A, LOAD_A, FILL_B, LOAD_B, DONE. Outputs are decoded from the registered state (Moore) plus the pack register.
- IDLE:
  - start=1 → FILL_A; element counter cleared.
  - start=0 → stay in IDLE.
- FILL_A / FILL_B:
  - in_ready=1.
  - Accept on in_valid&in_ready. The k-th accepted element (k=0..n-1) is written to bits [k*WIDTH +: WIDTH] of the current half.
  - On the n-th accept, go to LOAD_A or LOAD_B.
  - A cycle with no valid input holds all state.
- LOAD_A: in_ready=0, load=2'b01 for exactly one cycle, then FILL_B with the counter cleared.
- LOAD_B: in_ready=0, load=2'b10 for exactly one cycle, then DONE.
- DONE: done=1 for one cycle, then IDLE.
- inba is driven directly from the pack register:
  - Half A is not modified while half B fills.
  - Both halves hold their values after DONE until the next fill overwrites them element by element.
- start outside IDLE is ignored.
- Counter width is max(1, $clog2(n+1)). It counts 0..n-1 and never wraps past n-1.
- No data transformation; elements are bit-exact copies.

## Timing
- Reset values: state=IDLE, in_ready=0, load=2'b00, busy=0, done=0, inba=0, counter=0.
- rst asserted in any state, including mid-fill or during a load cycle:
  - Next cycle is IDLE with all reset values.
  - No load strobe is issued in the cycle after rst.
  - A partially filled half is discarded.
- Latency with in_valid held high (start sampled at cycle 0):
  - FILL_A: cycles 1..n
  - LOAD_A: cycle n+1
  - FILL_B: cycles n+2..2n+1
  - LOAD_B: cycle 2n+2
  - DONE: cycle 2n+3
  - IDLE: cycle 2n+4
- The downstream register captures at the clock edge ending each load cycle, so inba is stable throughout each load cycle.
- Back-pressure is input-side only: the block never stalls on the load outputs.

## Structure
- Shared package holds the state enum (6 states, 3-bit encoding) and the helper function for counter width.
- Optional sub-module `elem_packer` holds the pack register with indexed element write (inputs: half select, index, write enable, data). All other logic lives inline in merge_loader.

## Test plan
- Reset: after rst, check in_ready=0, load=0, busy=0, done=0, inba=12'h000 (WIDTH=3, n=2).
- Basic fill: start at cycle 0, stream 3,5,1,7 with valid always high.
  - Cycle 3: load=01, inba[5:0]=6'h2B.
  - Cycle 6: load=10, inba=12'hE6B.
  - Cycle 7: done=1.
  - Cycle 8: IDLE.
- Gaps: drop in_valid for 2 cycles after the first element.
  - Strobes shift later by exactly 2 cycles; the packed values are unchanged.
- Reset mid-operation: assert rst in the cycle after LOAD_A.
  - Next cycle is IDLE, inba=0.
  - load[1] is never asserted.
  - A fresh start then completes normally.
- Ignored start: pulse start during FILL_B. The sequence is unaffected and done fires exactly once.
- Edge case n=1, WIDTH=8: stream 8'hA5, 8'h3C → inba=16'h3CA5, load=01 at cycle 2, load=10 at cycle 4, done at cycle 5.
